detector_de_flags: RTL and testbench

DETECTOR_DE_FLAGS -- requirements
Module: detector_de_flags

---
 rtl/detector_de_flags_pkg.sv | 6 +
 rtl/detector_de_flags.sv | 38 +++
 tb/tb_detector_de_flags.sv | 119 +++++++++++
 3 files changed

// File: rtl/detector_de_flags_pkg.sv
// detector_de_flags_pkg: shared ALU constants for the flag detector
package detector_de_flags_pkg;
  localparam int DATA_W = 32;
  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;
endpackage

// File: rtl/detector_de_flags.sv
// detector_de_flags: registered signed-overflow, zero and sticky-overflow flags for the ALU
module detector_de_flags
  import detector_de_flags_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Enable_overflow,
  input  logic [DATA_W-1:0] Data,
  input  logic              Signal_A,
  input  logic              Signal_B,
  input  logic              Signal_Result,
  input  logic              Selection_Sum_Sub,
  input  logic              Clear_sticky,
  output logic              Overflow,
  output logic              Zero,
  output logic              Sticky_overflow
);
  logic ovf_next;
  logic zero_next;
  // next-state flags: overflow needs matching (add) or differing (sub) operand signs and a flipped result sign
  always_comb begin
    ovf_next  = Enable_overflow && (Signal_Result != Signal_A) &&
                ((Selection_Sum_Sub == SEL_SUB) ? (Signal_A != Signal_B) : (Signal_A == Signal_B));
    zero_next = ~|Data;
  end
  // flag registers; a new overflow beats a same-edge sticky clear
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Overflow        <= 1'b0;
      Zero            <= 1'b0;
      Sticky_overflow <= 1'b0;
    end else begin
      Overflow        <= ovf_next;
      Zero            <= zero_next;
      Sticky_overflow <= ovf_next | (Sticky_overflow & ~Clear_sticky);
    end
  end
endmodule

// File: tb/tb_detector_de_flags.sv
// tb_detector_de_flags: vector table, reset corner cases and randomized model check
module tb_detector_de_flags;
  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Enable_overflow = 1'b0;
  logic [31:0] Data = 32'h0;
  logic        Signal_A = 1'b0;
  logic        Signal_B = 1'b0;
  logic        Signal_Result = 1'b0;
  logic        Selection_Sum_Sub = 1'b0;
  logic        Clear_sticky = 1'b0;
  logic        Overflow, Zero, Sticky_overflow;
  int n_cmp = 0;
  int n_err = 0;

  detector_de_flags dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable_overflow(Enable_overflow), .Data(Data),
    .Signal_A(Signal_A), .Signal_B(Signal_B), .Signal_Result(Signal_Result),
    .Selection_Sum_Sub(Selection_Sum_Sub), .Clear_sticky(Clear_sticky),
    .Overflow(Overflow), .Zero(Zero), .Sticky_overflow(Sticky_overflow)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        en, sel, a, b, r, clr;
    logic [31:0] data;
    logic        eo, ez, es;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk3(input string tag, input logic eo, input logic ez, input logic es);
    chk({tag, ".overflow"}, Overflow, eo);
    chk({tag, ".zero"}, Zero, ez);
    chk({tag, ".sticky"}, Sticky_overflow, es);
  endtask

  task automatic drive(input logic en, input logic sel, input logic a, input logic b,
                       input logic r, input logic clr, input logic [31:0] d);
    Enable_overflow = en; Selection_Sum_Sub = sel; Signal_A = a; Signal_B = b;
    Signal_Result = r; Clear_sticky = clr; Data = d;
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic m_st, m_ovf, eb;
    vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5,        1'b1, 1'b0, 1'b1};
    vec[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7,        1'b1, 1'b0, 1'b1};
    vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1,        1'b0, 1'b0, 1'b1};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vec[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3,        1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3,        1'b0, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 1'b1};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1,        1'b1, 1'b0, 1'b1};
    vec[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1,        1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (2) tick;
    chk3("reset_hold", 1'b0, 1'b0, 1'b0);
    #2 Reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1);
    tick;
    chk3("first_edge_idle", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      drive(vec[i].en, vec[i].sel, vec[i].a, vec[i].b, vec[i].r, vec[i].clr, vec[i].data);
      tick;
      chk3($sformatf("vec%0d", i), vec[i].eo, vec[i].ez, vec[i].es);
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #2 Reset_n = 1'b0;
    #1 chk3("mid_op_reset", 1'b0, 1'b0, 1'b0);
    tick;
    chk3("reset_discard", 1'b0, 1'b0, 1'b0);
    #2 Reset_n = 1'b1;
    tick;
    chk3("post_reset_first", 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 Reset_n = 1'b0;
    #1 chk3("async_reset", 1'b0, 1'b0, 1'b0);
    #2 Reset_n = 1'b1;

    m_st = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic en, sel, a, b, r, clr;
      logic [31:0] d;
      en = 1'($urandom_range(0, 3) != 0);
      sel = 1'($urandom); a = 1'($urandom); b = 1'($urandom); r = 1'($urandom);
      clr = 1'($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
      drive(en, sel, a, b, r, clr, d);
      eb = sel ? ~b : b;
      m_ovf = en && (a == eb) && (r != a);
      m_st = m_ovf ? 1'b1 : (clr ? 1'b0 : m_st);
      tick;
      chk3($sformatf("rand%0d", i), m_ovf, d == 32'h0, m_st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
